// File: rtl/cmos_capture_roi.sv
// rtl/cmos_capture_roi.sv - DVP capture with ROI crop, frame decimation and geometry measurement
module cmos_capture_roi #(
    parameter int DATA_W        = 8,
    parameter int CNT_W         = 12,
    parameter int FRAME_WAITCNT = 10,
    parameter int PCLK_FREQ     = 24_000_000,
    parameter bit VS_POL        = 1'b1,
    parameter bit HS_POL        = 1'b1
) (
    input  logic              i_cmos_pclk,
    input  logic              i_rst_n,
    input  logic              i_cmos_vsync,
    input  logic              i_cmos_href,
    input  logic [DATA_W-1:0] i_cmos_data,
    input  logic              i_cfg_en,
    input  logic [CNT_W-1:0]  i_cfg_x_start,
    input  logic [CNT_W-1:0]  i_cfg_y_start,
    input  logic [CNT_W-1:0]  i_cfg_width,
    input  logic [CNT_W-1:0]  i_cfg_height,
    input  logic [3:0]        i_cfg_skip,
    output logic              o_frame_vsync,
    output logic              o_frame_href,
    output logic [DATA_W-1:0] o_frame_data,
    output logic              o_frame_start,
    output logic              o_frame_end,
    output logic [CNT_W-1:0]  o_frame_width,
    output logic [CNT_W-1:0]  o_frame_height,
    output logic [7:0]        o_fps_rate,
    output logic              o_sync_ok
);

    localparam int                WIN      = 2 * PCLK_FREQ;
    localparam int                WIN_W    = (WIN > 1) ? $clog2(WIN) : 1;
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [3:0]        WAIT_TGT = 4'(FRAME_WAITCNT);

    typedef enum logic [1:0] {ST_WAIT, ST_ARM, ST_RUN} state_t;

    state_t             state;
    logic [3:0]         wait_cnt;
    logic [1:0]         vs_q;
    logic [1:0]         hs_q;
    logic [DATA_W-1:0]  data_q1;
    logic [DATA_W-1:0]  data_q2;
    logic [CNT_W-1:0]   x_cnt;
    logic [CNT_W-1:0]   y_cnt;
    logic [CNT_W-1:0]   line_len;
    logic [CNT_W-1:0]   xs_l;
    logic [CNT_W-1:0]   ys_l;
    logic [CNT_W-1:0]   w_l;
    logic [CNT_W-1:0]   h_l;
    logic [3:0]         skip_cnt;
    logic               pass;
    logic [WIN_W-1:0]   win_cnt;
    logic [9:0]         fall_cnt;

    logic               vs1, vs2, hs1, hs2;
    logic               vs_rise, vs_fall, hs_fall;
    logic [CNT_W-1:0]   x_inc, y_inc;
    logic               x_in, y_in, roi, fv_next;

    assign vs1     = (vs_q[0] == VS_POL);
    assign vs2     = (vs_q[1] == VS_POL);
    assign hs1     = (hs_q[0] == HS_POL);
    assign hs2     = (hs_q[1] == HS_POL);
    assign vs_rise = vs1 & ~vs2;
    assign vs_fall = ~vs1 & vs2;
    assign hs_fall = ~hs1 & hs2;

    assign x_inc = (x_cnt == CNT_MAX) ? x_cnt : x_cnt + 1'b1;
    assign y_inc = (y_cnt == CNT_MAX) ? y_cnt : y_cnt + 1'b1;

    // One extra bit keeps start+size from wrapping near the top of the counter range
    assign x_in = ({1'b0, x_cnt} >= {1'b0, xs_l}) &&
                  ({1'b0, x_cnt} <  ({1'b0, xs_l} + {1'b0, w_l}));
    assign y_in = ({1'b0, y_cnt} >= {1'b0, ys_l}) &&
                  ({1'b0, y_cnt} <  ({1'b0, ys_l} + {1'b0, h_l}));
    assign roi     = pass & vs2 & hs2 & x_in & y_in;
    assign fv_next = vs2 & pass;

    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vs_q    <= '0;
            hs_q    <= '0;
            data_q1 <= '0;
            data_q2 <= '0;
        end else begin
            vs_q    <= {vs_q[0], i_cmos_vsync};
            hs_q    <= {hs_q[0], i_cmos_href};
            data_q1 <= i_cmos_data;
            data_q2 <= data_q1;
        end
    end

    // The armed state waits out one more frame so the first passed frame begins at a clean vs_rise
    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_WAIT;
            wait_cnt  <= '0;
            o_sync_ok <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == WAIT_TGT)
                        state <= ST_ARM;
                    else if (vs_fall)
                        wait_cnt <= wait_cnt + 4'd1;
                end
                ST_ARM: begin
                    if (vs_fall) begin
                        state     <= ST_RUN;
                        o_sync_ok <= 1'b1;
                    end
                end
                ST_RUN:  o_sync_ok <= 1'b1;
                default: state <= ST_WAIT;
            endcase
        end
    end

    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            xs_l     <= '0;
            ys_l     <= '0;
            w_l      <= '0;
            h_l      <= '0;
            pass     <= 1'b0;
            skip_cnt <= '0;
        end else begin
            if (vs_rise) begin
                xs_l <= i_cfg_x_start;
                ys_l <= i_cfg_y_start;
                w_l  <= i_cfg_width;
                h_l  <= i_cfg_height;
                pass <= (state == ST_RUN) & i_cfg_en & (skip_cnt == 4'd0);
            end
            if (state != ST_RUN)
                skip_cnt <= '0;
            else if (vs_rise)
                skip_cnt <= (skip_cnt >= i_cfg_skip) ? 4'd0 : skip_cnt + 4'd1;
        end
    end

    // x tracks the column of the pixel now in stage 2; y the line it belongs to
    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_cnt          <= '0;
            y_cnt          <= '0;
            line_len       <= '0;
            o_frame_width  <= '0;
            o_frame_height <= '0;
        end else begin
            if (hs1 && hs2)
                x_cnt <= x_inc;
            else
                x_cnt <= '0;
            if (vs_rise) begin
                y_cnt    <= '0;
                line_len <= '0;
            end else if (hs_fall) begin
                y_cnt    <= y_inc;
                line_len <= x_inc;
            end
            if (vs_fall) begin
                o_frame_height <= hs_fall ? y_inc : y_cnt;
                o_frame_width  <= hs_fall ? x_inc : line_len;
            end
        end
    end

    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_frame_vsync <= 1'b0;
            o_frame_start <= 1'b0;
            o_frame_end   <= 1'b0;
            o_frame_href  <= 1'b0;
            o_frame_data  <= '0;
        end else begin
            o_frame_vsync <= fv_next;
            o_frame_start <= fv_next & ~o_frame_vsync;
            o_frame_end   <= ~fv_next & o_frame_vsync;
            o_frame_href  <= roi;
            o_frame_data  <= roi ? data_q2 : '0;
        end
    end

    // A vs_fall on the terminal cycle opens the new window's count
    always_ff @(posedge i_cmos_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            win_cnt    <= '0;
            fall_cnt   <= '0;
            o_fps_rate <= '0;
        end else if (win_cnt == WIN_LAST) begin
            win_cnt    <= '0;
            o_fps_rate <= fall_cnt[9] ? 8'hFF : fall_cnt[8:1];
            fall_cnt   <= vs_fall ? 10'd1 : 10'd0;
        end else begin
            win_cnt <= win_cnt + 1'b1;
            if (vs_fall && fall_cnt != 10'h3FF)
                fall_cnt <= fall_cnt + 10'd1;
        end
    end

endmodule

// File: tb/tb_cmos_capture_roi.sv
// tb/tb_cmos_capture_roi.sv - directed vector bench for cmos_capture_roi
module tb_cmos_capture_roi;

    typedef struct packed {
        logic        en;
        logic [11:0] xs;
        logic [11:0] ys;
        logic [11:0] w;
        logic [11:0] h;
        logic [3:0]  skip;
    } cfg_t;

    typedef struct {
        cfg_t c;
        bit   chg;
        cfg_t c2;
        int   cols, lines, e_st, e_hr, e_sum, e_w, e_h;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] data = 8'h55;
    cfg_t       cur = '0;
    logic       vsync_n, href_n;

    logic       a_vs, a_hr, a_st, a_en, a_ok;
    logic [7:0] a_d, a_fps;
    logic [11:0] a_w, a_h;
    logic       b_vs, b_hr, b_st, b_en, b_ok;
    logic [7:0] b_d, b_fps;
    logic [11:0] b_w, b_h;

    int n_chk = 0;
    int n_fail = 0;
    logic mon_clr = 1'b1;
    int st_a, en_a, hr_a, sum_a, st_b, hr_b, sum_b, bad;
    logic [8:0] ph1 = '0, ph2 = '0;
    vec_t vt[17];

    assign vsync_n = ~vsync;
    assign href_n  = ~href;

    always #5 clk = ~clk;

    cmos_capture_roi #(.DATA_W(8), .CNT_W(12), .FRAME_WAITCNT(2), .PCLK_FREQ(100),
                       .VS_POL(1'b1), .HS_POL(1'b1)) dut (
        .i_cmos_pclk(clk), .i_rst_n(rst_n), .i_cmos_vsync(vsync), .i_cmos_href(href),
        .i_cmos_data(data), .i_cfg_en(cur.en), .i_cfg_x_start(cur.xs), .i_cfg_y_start(cur.ys),
        .i_cfg_width(cur.w), .i_cfg_height(cur.h), .i_cfg_skip(cur.skip),
        .o_frame_vsync(a_vs), .o_frame_href(a_hr), .o_frame_data(a_d), .o_frame_start(a_st),
        .o_frame_end(a_en), .o_frame_width(a_w), .o_frame_height(a_h), .o_fps_rate(a_fps),
        .o_sync_ok(a_ok));

    cmos_capture_roi #(.DATA_W(8), .CNT_W(12), .FRAME_WAITCNT(2), .PCLK_FREQ(100),
                       .VS_POL(1'b0), .HS_POL(1'b0)) dut_n (
        .i_cmos_pclk(clk), .i_rst_n(rst_n), .i_cmos_vsync(vsync_n), .i_cmos_href(href_n),
        .i_cmos_data(data), .i_cfg_en(cur.en), .i_cfg_x_start(cur.xs), .i_cfg_y_start(cur.ys),
        .i_cfg_width(cur.w), .i_cfg_height(cur.h), .i_cfg_skip(cur.skip),
        .o_frame_vsync(b_vs), .o_frame_href(b_hr), .o_frame_data(b_d), .o_frame_start(b_st),
        .o_frame_end(b_en), .o_frame_width(b_w), .o_frame_height(b_h), .o_fps_rate(b_fps),
        .o_sync_ok(b_ok));

    // Output at edge j must reflect the pins sampled at edge j-2
    always @(posedge clk) begin
        #1;
        if (mon_clr) begin
            st_a = 0; en_a = 0; hr_a = 0; sum_a = 0;
            st_b = 0; hr_b = 0; sum_b = 0; bad = 0;
        end else begin
            if (a_st) st_a++;
            if (a_en) en_a++;
            if (a_hr) begin hr_a++; sum_a += int'(a_d); end
            if (b_st) st_b++;
            if (b_hr) begin hr_b++; sum_b += int'(b_d); end
            if (!a_hr && a_d != 8'h00) bad++;
            if (!b_hr && b_d != 8'h00) bad++;
            if (a_hr && (a_d != ph2[7:0] || !ph2[8])) bad++;
            if (b_hr && (b_d != ph2[7:0] || !ph2[8])) bad++;
        end
        ph2 = ph1;
        ph1 = {href, data};
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        mon_clr = 1'b1;
        @(posedge clk);
        #2;
        mon_clr = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input int cols, input int lines, input bit chg, input cfg_t c2);
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < cols; x++) begin
                href = 1'b1;
                data = {1'b1, y[2:0], x[3:0]};
                @(negedge clk);
            end
            href = 1'b0;
            data = 8'h55;
            repeat (4) @(negedge clk);
            if (y == 0 && chg) cur = c2;
        end
        repeat (2) @(negedge clk);
        vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " vsync"}, a_vs, 0);
        chk({tag, " href"}, a_hr, 0);
        chk({tag, " data"}, a_d, 0);
        chk({tag, " start"}, a_st, 0);
        chk({tag, " end"}, a_en, 0);
        chk({tag, " width"}, a_w, 0);
        chk({tag, " height"}, a_h, 0);
        chk({tag, " fps"}, a_fps, 0);
        chk({tag, " sync_ok"}, a_ok, 0);
    endtask

    function automatic cfg_t cf(input int en, input int xs, input int ys, input int w,
                                input int h, input int sk);
        cfg_t c;
        c.en = en[0]; c.xs = 12'(xs); c.ys = 12'(ys);
        c.w = 12'(w); c.h = 12'(h); c.skip = 4'(sk);
        return c;
    endfunction

    function automatic vec_t vv(input cfg_t c, input bit chg, input cfg_t c2, input int cols,
                                input int lines, input int st, input int hr, input int sm,
                                input int w, input int h);
        vec_t v;
        v.c = c; v.chg = chg; v.c2 = c2; v.cols = cols; v.lines = lines;
        v.e_st = st; v.e_hr = hr; v.e_sum = sm; v.e_w = w; v.e_h = h;
        return v;
    endfunction

    initial begin
        cfg_t full, r1, s2;
        string p;
        full = cf(1, 0, 0, 8, 4, 0);
        r1   = cf(1, 2, 1, 3, 2, 0);
        s2   = cf(1, 0, 0, 8, 4, 2);
        vt[0]  = vv(full, 0, full, 8, 4, 1, 32, 4976, 8, 4);
        vt[1]  = vv(r1,   0, full, 8, 4, 1, 6, 930, 8, 4);
        vt[2]  = vv(r1,   1, full, 8, 4, 1, 6, 930, 8, 4);
        vt[3]  = vv(full, 0, full, 8, 4, 1, 32, 4976, 8, 4);
        vt[4]  = vv(s2,   0, s2, 8, 4, 1, 32, 4976, 8, 4);
        vt[5]  = vv(s2,   0, s2, 8, 3, 0, 0, 0, 8, 3);
        vt[6]  = vv(s2,   0, s2, 8, 2, 0, 0, 0, 8, 2);
        vt[7]  = vv(s2,   0, s2, 8, 4, 1, 32, 4976, 8, 4);
        vt[8]  = vv(s2,   0, s2, 6, 1, 0, 0, 0, 6, 1);
        vt[9]  = vv(s2,   0, s2, 8, 2, 0, 0, 0, 8, 2);
        vt[10] = vv(s2,   0, s2, 8, 4, 1, 32, 4976, 8, 4);
        vt[11] = vv(s2,   0, s2, 8, 3, 0, 0, 0, 8, 3);
        vt[12] = vv(s2,   0, s2, 8, 4, 0, 0, 0, 8, 4);
        vt[13] = vv(cf(0, 0, 0, 8, 4, 0), 0, full, 8, 4, 0, 0, 0, 8, 4);
        vt[14] = vv(cf(1, 0, 0, 0, 4, 0), 0, full, 8, 4, 1, 0, 0, 8, 4);
        vt[15] = vv(cf(1, 0, 0, 8, 0, 0), 0, full, 8, 4, 1, 0, 0, 8, 4);
        vt[16] = vv(cf(1, 4090, 0, 100, 1, 0), 0, full, 4100, 1, 1, 10, 1361, 4095, 1);

        #2 rst_n = 1'b0;
        #1 chk_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cur = full;

        clr();
        for (int f = 1; f <= 3; f++) begin
            send_frame(8, 4, 0, full);
            chk($sformatf("sync_ok after frame %0d", f), a_ok, (f == 3) ? 1 : 0);
        end
        chk("no start before run", st_a, 0);

        for (int i = 0; i < 17; i++) begin
            cur = vt[i].c;
            clr();
            send_frame(vt[i].cols, vt[i].lines, vt[i].chg, vt[i].c2);
            p = $sformatf("v%0d", i);
            chk({p, " start"}, st_a, vt[i].e_st);
            chk({p, " end"}, en_a, vt[i].e_st);
            chk({p, " href"}, hr_a, vt[i].e_hr);
            chk({p, " sum"}, sum_a, vt[i].e_sum);
            chk({p, " width"}, a_w, vt[i].e_w);
            chk({p, " height"}, a_h, vt[i].e_h);
            chk({p, " gating"}, bad, 0);
            chk({p, " neg start"}, st_b, vt[i].e_st);
            chk({p, " neg href"}, hr_b, vt[i].e_hr);
            chk({p, " neg sum"}, sum_b, vt[i].e_sum);
        end

        cur = full;
        clr();
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        href = 1'b1;
        for (int x = 0; x < 4; x++) begin
            data = {4'h8, x[3:0]};
            @(negedge clk);
        end
        @(posedge clk);
        #2;
        chk("midframe vsync", a_vs, 1);
        chk("midframe href", a_hr, 1);
        rst_n = 1'b0;
        #1 chk_zero("async reset");
        vsync = 1'b0;
        href = 1'b0;
        data = 8'h55;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        clr();
        for (int f = 1; f <= 5; f++) begin
            vsync = 1'b1;
            repeat (8) @(negedge clk);
            vsync = 1'b0;
            repeat (8) @(negedge clk);
            if (f == 2) begin
                chk("resync sync_ok f2", a_ok, 0);
                chk("resync start f2", st_a, 0);
            end
        end
        chk("resync sync_ok f5", a_ok, 1);
        chk("resync start f5", st_a, 2);
        repeat (128) @(negedge clk);
        chk("fps window 1", a_fps, 2);
        repeat (200) @(negedge clk);
        chk("fps window 2", a_fps, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
